// File: rtl/mux_nx1_stripe_if.sv
// rtl/mux_nx1_stripe_if.sv - frame-in / serial-out bus of the lane unstriping multiplexer
interface mux_nx1_stripe_if #(
    parameter int NUM_LANES = 4,
    parameter int WIDTH     = 8
);
    logic [NUM_LANES*WIDTH-1:0] in_data;
    logic [NUM_LANES-1:0]       in_valid;
    logic                       in_load;
    logic                       in_ready;
    logic [WIDTH-1:0]           out;
    logic                       valid_out;
    logic                       frame_done;
    logic                       busy;

    modport master (
        output in_data, in_valid, in_load,
        input  in_ready, out, valid_out, frame_done, busy
    );

    modport slave (
        input  in_data, in_valid, in_load,
        output in_ready, out, valid_out, frame_done, busy
    );
endinterface

// File: rtl/mux_nx1_stripe.sv
// rtl/mux_nx1_stripe.sv - NUM_LANES:1 lane serializer with holding buffer and optional invalid-lane skipping
module mux_nx1_stripe #(
    parameter int NUM_LANES    = 4,
    parameter int WIDTH        = 8,
    parameter int SKIP_INVALID = 0
) (
    input  logic            clk,
    input  logic            reset,
    mux_nx1_stripe_if.slave bus
);
    localparam int IDXW = $clog2(NUM_LANES);
    localparam int DW   = NUM_LANES * WIDTH;
    typedef logic [IDXW-1:0] idx_t;

    logic [DW-1:0]        r_h_data;
    logic [NUM_LANES-1:0] r_h_valid;
    logic                 r_h_full;
    logic [DW-1:0]        r_s_data;
    logic [NUM_LANES-1:0] r_s_valid;
    logic [NUM_LANES-1:0] r_s_sel;
    idx_t                 r_phase;
    logic                 r_s_active;
    logic [WIDTH-1:0]     r_out;
    logic                 r_valid_out;
    logic                 r_frame_done;
    logic                 r_busy;

    logic                 w_in_ready;
    logic [NUM_LANES-1:0] w_h_sel;
    idx_t                 w_s_idx;
    logic                 w_s_more;
    idx_t                 w_h_idx;
    logic                 w_h_more;
    logic [WIDTH-1:0]     w_out_nxt;
    logic                 w_vld_nxt;
    logic                 w_done_nxt;
    logic                 w_s_active_nxt;
    logic                 w_h_full_nxt;
    logic                 w_load_s;
    logic                 w_accept;
    idx_t                 w_phase_nxt;

    function automatic idx_t first_at_or_above(input logic [NUM_LANES-1:0] mask, input int lo);
        idx_t res;
        res = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (i >= lo && mask[i]) res = idx_t'(i);
        end
        return res;
    endfunction

    function automatic logic any_above(input logic [NUM_LANES-1:0] mask, input idx_t idx);
        return (mask >> (int'(idx) + 1)) != '0;
    endfunction

    function automatic logic [WIDTH-1:0] lane_of(input logic [DW-1:0] data, input idx_t idx);
        return data[int'(idx)*WIDTH +: WIDTH];
    endfunction

    assign w_in_ready = !r_h_full && !reset;
    assign w_accept   = bus.in_load && w_in_ready;

    // Slot selection mask: every lane in bubble mode, only valid lanes in skip mode.
    assign w_h_sel  = (SKIP_INVALID != 0) ? r_h_valid : {NUM_LANES{1'b1}};
    assign w_s_idx  = first_at_or_above(r_s_sel, int'(r_phase) + 1);
    assign w_s_more = any_above(r_s_sel, w_s_idx);
    assign w_h_idx  = first_at_or_above(w_h_sel, 0);
    assign w_h_more = any_above(w_h_sel, w_h_idx);

    always_comb begin
        w_out_nxt      = '0;
        w_vld_nxt      = 1'b0;
        w_done_nxt     = 1'b0;
        w_s_active_nxt = r_s_active;
        w_h_full_nxt   = r_h_full;
        w_load_s       = 1'b0;
        w_phase_nxt    = r_phase;
        if (r_s_active) begin
            w_phase_nxt    = w_s_idx;
            w_vld_nxt      = r_s_valid[w_s_idx];
            w_out_nxt      = w_vld_nxt ? lane_of(r_s_data, w_s_idx) : '0;
            w_done_nxt     = !w_s_more;
            w_s_active_nxt = w_s_more;
        end else if (r_h_full) begin
            // An empty skip-mode frame is dropped here without occupying a slot.
            w_h_full_nxt = 1'b0;
            if (|w_h_sel) begin
                w_load_s       = 1'b1;
                w_phase_nxt    = w_h_idx;
                w_vld_nxt      = r_h_valid[w_h_idx];
                w_out_nxt      = w_vld_nxt ? lane_of(r_h_data, w_h_idx) : '0;
                w_done_nxt     = !w_h_more;
                w_s_active_nxt = w_h_more;
            end
        end
        if (w_accept) w_h_full_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_data     <= '0;
            r_h_valid    <= '0;
            r_h_full     <= 1'b0;
            r_s_data     <= '0;
            r_s_valid    <= '0;
            r_s_sel      <= '0;
            r_phase      <= '0;
            r_s_active   <= 1'b0;
            r_out        <= '0;
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_h_data  <= bus.in_data;
                r_h_valid <= bus.in_valid;
            end
            if (w_load_s) begin
                r_s_data  <= r_h_data;
                r_s_valid <= r_h_valid;
                r_s_sel   <= w_h_sel;
            end
            r_h_full     <= w_h_full_nxt;
            r_phase      <= w_phase_nxt;
            r_s_active   <= w_s_active_nxt;
            r_out        <= w_out_nxt;
            r_valid_out  <= w_vld_nxt;
            r_frame_done <= w_done_nxt;
            r_busy       <= w_s_active_nxt || w_h_full_nxt;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out        = r_out;
    assign bus.valid_out  = r_valid_out;
    assign bus.frame_done = r_frame_done;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_mux_nx1_stripe.sv
// tb/tb_mux_nx1_stripe.sv - bench for three mux_nx1_stripe configurations against a slot-queue model
module tb_mux_nx1_stripe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mux_nx1_stripe_if #(.NUM_LANES(4), .WIDTH(8))  b0();
    mux_nx1_stripe_if #(.NUM_LANES(4), .WIDTH(8))  b1();
    mux_nx1_stripe_if #(.NUM_LANES(8), .WIDTH(16)) b2();

    mux_nx1_stripe #(.NUM_LANES(4), .WIDTH(8),  .SKIP_INVALID(0)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
    mux_nx1_stripe #(.NUM_LANES(4), .WIDTH(8),  .SKIP_INVALID(1)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
    mux_nx1_stripe #(.NUM_LANES(8), .WIDTH(16), .SKIP_INVALID(0)) u2 (.clk(clk), .reset(reset), .bus(b2.slave));

    typedef struct packed {logic [15:0] d; logic v; logic done;} slot_t;
    typedef struct packed {logic [127:0] d; logic [7:0] v;} frame_t;

    int lanes[3] = '{4, 4, 8};
    int wd[3]    = '{8, 8, 16};
    bit skip[3]  = '{1'b0, 1'b1, 1'b0};

    logic [127:0] d_data[3];
    logic [7:0]   d_valid[3];
    logic         d_load[3];

    assign b0.in_data  = d_data[0][31:0];
    assign b0.in_valid = d_valid[0][3:0];
    assign b0.in_load  = d_load[0];
    assign b1.in_data  = d_data[1][31:0];
    assign b1.in_valid = d_valid[1][3:0];
    assign b1.in_load  = d_load[1];
    assign b2.in_data  = d_data[2];
    assign b2.in_valid = d_valid[2];
    assign b2.in_load  = d_load[2];

    logic [15:0] o_out[3];
    logic        o_vld[3], o_done[3], o_busy[3], o_rdy[3];
    assign o_out[0] = {8'h00, b0.out};
    assign o_out[1] = {8'h00, b1.out};
    assign o_out[2] = b2.out;
    assign o_vld[0] = b0.valid_out;
    assign o_vld[1] = b1.valid_out;
    assign o_vld[2] = b2.valid_out;
    assign o_done[0] = b0.frame_done;
    assign o_done[1] = b1.frame_done;
    assign o_done[2] = b2.frame_done;
    assign o_busy[0] = b0.busy;
    assign o_busy[1] = b1.busy;
    assign o_busy[2] = b2.busy;
    assign o_rdy[0] = b0.in_ready;
    assign o_rdy[1] = b1.in_ready;
    assign o_rdy[2] = b2.in_ready;

    // Reference: a pending-frame slot and a queue of slots still to be emitted.
    slot_t        sq[3][$];
    frame_t       fq[3][$];
    logic         h_full[3];
    logic [127:0] h_data[3];
    logic [7:0]   h_valid[3];
    slot_t        exp_s[3];
    logic         exp_busy[3];
    logic         accepted[3];
    bit           gaps = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lane_of(input logic [127:0] d, input int i, input int w);
        logic [127:0] m;
        m = (128'd1 << w) - 128'd1;
        return 16'((d >> (i * w)) & m);
    endfunction

    function automatic logic [127:0] mk_frame(input int k, input int f);
        logic [127:0] d;
        logic [127:0] v;
        d = '0;
        for (int i = 0; i < lanes[k]; i++) begin
            v = (k < 2) ? 128'(8'h11 * (f * lanes[k] + i + 1)) : 128'(f * lanes[k] + i + 1);
            d = d | (v << (i * wd[k]));
        end
        return d;
    endfunction

    task automatic model_step(input int k);
        slot_t lst[$];
        slot_t s;
        bit    rdy;
        accepted[k] = 1'b0;
        exp_s[k] = '0;
        if (reset) begin
            sq[k].delete();
            h_full[k] = 1'b0;
        end else begin
            rdy = !h_full[k];
            if (sq[k].size() > 0) begin
                exp_s[k] = sq[k].pop_front();
            end else if (h_full[k]) begin
                h_full[k] = 1'b0;
                for (int i = 0; i < lanes[k]; i++) begin
                    if (skip[k] && !h_valid[k][i]) continue;
                    s.v = h_valid[k][i];
                    s.d = s.v ? lane_of(h_data[k], i, wd[k]) : 16'h0;
                    s.done = 1'b0;
                    lst.push_back(s);
                end
                if (lst.size() > 0) begin
                    lst[lst.size()-1].done = 1'b1;
                    exp_s[k] = lst.pop_front();
                    sq[k] = lst;
                end
            end
            if (d_load[k] && rdy) begin
                h_data[k]   = d_data[k];
                h_valid[k]  = d_valid[k];
                h_full[k]   = 1'b1;
                accepted[k] = 1'b1;
            end
        end
        exp_busy[k] = (sq[k].size() > 0) || h_full[k];
    endtask

    task automatic drive(input int k);
        frame_t f;
        if (!d_load[k] || accepted[k]) begin
            if (fq[k].size() > 0 && !(gaps && $urandom_range(0, 3) == 0)) begin
                f = fq[k].pop_front();
                d_data[k]  = f.d;
                d_valid[k] = f.v;
                d_load[k]  = 1'b1;
            end else begin
                d_load[k] = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("out[%0d]", k), {16'h0, o_out[k]}, {16'h0, exp_s[k].d});
            check($sformatf("valid_out[%0d]", k), {31'h0, o_vld[k]}, {31'h0, exp_s[k].v});
            check($sformatf("frame_done[%0d]", k), {31'h0, o_done[k]}, {31'h0, exp_s[k].done});
            check($sformatf("busy[%0d]", k), {31'h0, o_busy[k]}, {31'h0, exp_busy[k]});
            check($sformatf("in_ready[%0d]", k), {31'h0, o_rdy[k]}, {31'h0, !h_full[k] && !reset});
        end
        for (int k = 0; k < 3; k++) drive(k);
    endtask

    task automatic push_all(input int f, input logic [7:0] v);
        for (int k = 0; k < 3; k++) fq[k].push_back('{d: mk_frame(k, f), v: v});
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            d_data[k] = '0; d_valid[k] = '0; d_load[k] = 1'b0;
            h_full[k] = 1'b0; h_data[k] = '0; h_valid[k] = '0;
            accepted[k] = 1'b0; exp_busy[k] = 1'b0; exp_s[k] = '0;
        end
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;

        push_all(0, 8'hFF);
        repeat (14) cycle();

        for (int f = 0; f < 3; f++) push_all(f, 8'hFF);
        repeat (34) cycle();

        push_all(0, 8'h0A);
        push_all(0, 8'h05);
        push_all(1, 8'h00);
        push_all(2, 8'hFF);
        repeat (44) cycle();

        push_all(0, 8'hFF);
        repeat (4) cycle();
        reset = 1'b1;
        push_all(1, 8'hFF);
        repeat (2) cycle();
        reset = 1'b0;
        repeat (24) cycle();

        gaps = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (fq[k].size() < 2)
                    fq[k].push_back('{d: {$urandom, $urandom, $urandom, $urandom},
                                      v: ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom)});
            end
            reset = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 1'b0;
        gaps = 1'b0;
        repeat (40) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
